// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - instruction/data memory handshake bundle for the multicycle sequencer
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle CPU control sequencer with memory timeout and sticky errors
// Optional SEQ_PERF_CNT_EN adds a 32-bit retired-instruction counter output (instret).
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              opcode,
    input  logic                    regWrite,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    multicycle_sequencer_if.master  mem,
    output logic                    ir_load,
    output logic                    pc_write,
    output logic                    rf_we,
    output logic [2:0]              state,
    output logic                    err_illegal,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]             instret,
`endif
    output logic                    err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic       illegal;
    logic       mem_access;
    logic       timeout_hit;

    assign state       = state_q;
    assign mem_access  = MemRead | MemWrite;
    assign timeout_hit = (wait_cnt == WAIT_MAX) && !mem.dmem_ack;

    always_comb begin
        illegal = 1'b1;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1100111: illegal = 1'b0;
            default:                            illegal = 1'b1;
        endcase
        if (MemRead && MemWrite)
            illegal = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem.imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = mem_access ? S_MEM : S_WB;
            // An ack on the final permitted cycle still completes the access.
            S_MEM: begin
                if (mem.dmem_ack)
                    state_d = S_WB;
                else if (timeout_hit)
                    state_d = S_HALT;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        rf_we        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                ir_load      = mem.imem_ack;
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = MemWrite;
            end
            S_WB: begin
                pc_write = 1'b1;
                rf_we    = regWrite & ~MemWrite;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 8'd0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state_q == S_EXEC)
                wait_cnt <= 8'd0;
            else if (state_q == S_MEM && !mem.dmem_ack && !timeout_hit)
                wait_cnt <= wait_cnt + 8'd1;
            if (state_q == S_DECODE && illegal)
                err_illegal <= 1'b1;
            if (state_q == S_MEM && timeout_hit)
                err_timeout <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= 32'd0;
        else if (state_q == S_WB)
            instret <= instret + 32'd1;
    end
`endif

endmodule
